// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, status codes, sequencer states and memory-icode lookup.
// Pure declarations, no logic or timing of its own.
package y86_pkg;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_F    = 3'd1,
        S_D    = 3'd2,
        S_E    = 3'd3,
        S_M    = 3'd4,
        S_W    = 3'd5,
        S_HALT = 3'd6
    } state_t;

    function automatic logic mem_icode(input logic [3:0] ic);
        return (ic == ICODE_RMMOVQ) || (ic == ICODE_MRMOVQ) ||
               (ic == ICODE_CALL)   || (ic == ICODE_RET)    ||
               (ic == ICODE_PUSHQ)  || (ic == ICODE_POPQ);
    endfunction

endpackage

// File: rtl/y86_seq_ctrl_if.sv
// Sequencer-side bundle: fetch/execute/memory results in, PC, stage enables and status out.
// master = sequencer; slave = surrounding datapath and memory model.
interface y86_seq_ctrl_if;

    logic        start;
    logic [3:0]  icode;
    logic        instr_valid;
    logic        imem_error;
    logic        hlt;
    logic [63:0] valC;
    logic [63:0] valP;
    logic        Cnd;
    logic [63:0] valM;
    logic        dmem_ack;
    logic        dmem_error;

    logic [63:0] PC;
    logic        f_en;
    logic        d_en;
    logic        e_en;
    logic        m_en;
    logic        w_en;
    logic        dmem_req;
    logic [2:0]  stat;
    logic        running;
    logic [31:0] instr_count;

    modport master (
        input  start, icode, instr_valid, imem_error, hlt, valC, valP,
               Cnd, valM, dmem_ack, dmem_error,
        output PC, f_en, d_en, e_en, m_en, w_en, dmem_req, stat, running,
               instr_count
    );

    modport slave (
        output start, icode, instr_valid, imem_error, hlt, valC, valP,
               Cnd, valM, dmem_ack, dmem_error,
        input  PC, f_en, d_en, e_en, m_en, w_en, dmem_req, stat, running,
               instr_count
    );

endinterface

// File: rtl/y86_pc_sel.sv
// Combinational next-PC select for call/jXX/ret/fall-through.
// Zero latency; no handshake.
module y86_pc_sel
    import y86_pkg::*;
(
    input  logic [3:0]  i_icode,
    input  logic        i_cnd,
    input  logic [63:0] i_valc,
    input  logic [63:0] i_valp,
    input  logic [63:0] i_valm,
    output logic [63:0] o_new_pc
);

    always_comb begin
        o_new_pc = i_valp;
        case (i_icode)
            ICODE_CALL: o_new_pc = i_valc;
            ICODE_JXX:  o_new_pc = i_cnd ? i_valc : i_valp;
            ICODE_RET:  o_new_pc = i_valm;
            default:    o_new_pc = i_valp;
        endcase
    end

endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle F/D/E/M/W sequencer owning PC, status and retire count; 5 cycles per instruction
// plus data-memory ack latency; dmem_req is held until ack or MEM_TIMEOUT request cycles elapse.
module y86_seq_ctrl
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int          MEM_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           rst_n,
    y86_seq_ctrl_if.master bus
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  w_halt_stat;
    logic [63:0] r_pc;
    logic [2:0]  r_stat;
    logic [31:0] r_count;
    logic [7:0]  r_wait;
    logic [3:0]  r_icode;
    logic [63:0] r_valc;
    logic [63:0] r_valp;
    logic [63:0] r_valm;
    logic        r_cnd;
    logic        w_is_mem;
    logic [63:0] w_new_pc;

    assign w_is_mem = mem_icode(r_icode);

    y86_pc_sel u_pc_sel (
        .i_icode  (r_icode),
        .i_cnd    (r_cnd),
        .i_valc   (r_valc),
        .i_valp   (r_valp),
        .i_valm   (r_valm),
        .o_new_pc (w_new_pc)
    );

    always_comb begin
        w_next_state = r_state;
        w_halt_stat  = r_stat;
        case (r_state)
            S_IDLE: if (bus.start) w_next_state = S_F;
            S_F: begin
                // Fault priority: imem_error beats invalid instruction beats halt.
                if (bus.imem_error) begin
                    w_next_state = S_HALT;
                    w_halt_stat  = STAT_ADR;
                end else if (!bus.instr_valid) begin
                    w_next_state = S_HALT;
                    w_halt_stat  = STAT_INS;
                end else if (bus.hlt) begin
                    w_next_state = S_HALT;
                    w_halt_stat  = STAT_HLT;
                end else begin
                    w_next_state = S_D;
                end
            end
            S_D: w_next_state = S_E;
            S_E: w_next_state = S_M;
            S_M: begin
                if (!w_is_mem) begin
                    w_next_state = S_W;
                end else if (bus.dmem_ack) begin
                    w_next_state = bus.dmem_error ? S_HALT : S_W;
                    if (bus.dmem_error) w_halt_stat = STAT_ADR;
                end else if (r_wait == WAIT_LAST) begin
                    w_next_state = S_HALT;
                    w_halt_stat  = STAT_ADR;
                end
            end
            S_W:     w_next_state = S_F;
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_stat  <= STAT_AOK;
            r_count <= 32'd0;
            r_wait  <= 8'd0;
            r_icode <= ICODE_NOP;
            r_valc  <= 64'd0;
            r_valp  <= 64'd0;
            r_valm  <= 64'd0;
            r_cnd   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_F) begin
                r_icode <= bus.icode;
                r_valc  <= bus.valC;
                r_valp  <= bus.valP;
            end
            if (r_state == S_E) r_cnd <= bus.Cnd;
            if (r_state == S_M && w_is_mem && bus.dmem_ack) r_valm <= bus.valM;
            if (r_state == S_M && w_is_mem && w_next_state == S_M) begin
                r_wait <= r_wait + 8'd1;
            end else begin
                r_wait <= 8'd0;
            end
            if (r_state != S_HALT && w_next_state == S_HALT) r_stat <= w_halt_stat;
            if (r_state == S_W) begin
                r_pc    <= w_new_pc;
                r_count <= r_count + 32'd1;
            end
        end
    end

    assign bus.PC          = r_pc;
    assign bus.stat        = r_stat;
    assign bus.instr_count = r_count;
    assign bus.f_en        = (r_state == S_F);
    assign bus.d_en        = (r_state == S_D);
    assign bus.e_en        = (r_state == S_E);
    assign bus.m_en        = (r_state == S_M);
    assign bus.w_en        = (r_state == S_W);
    assign bus.dmem_req    = (r_state == S_M) && w_is_mem;
    assign bus.running     = (r_state == S_F) || (r_state == S_D) || (r_state == S_E) ||
                             (r_state == S_M) || (r_state == S_W);

endmodule
